// File: rtl/tick_countdown_timer.sv
// Tick-driven down-counter with one-shot/auto-reload modes,
// sticky expiry IRQ and overrun flag.
module tick_countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK_IN,
    input  logic             n_RST,
    input  logic             TICK_IN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             START,
    input  logic             STOP,
    input  logic             AUTO,
    input  logic             IRQ_ACK,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             IRQ,
    output logic             OVERRUN
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q;
    logic             irq_q, ovr_q;
    logic             tick_prev_q;
    logic             tick;
    logic             expire;
    logic [WIDTH-1:0] eff_count;

    assign tick      = TICK_IN & ~tick_prev_q;
    assign eff_count = LOAD ? LOAD_VAL : count_q;

    // Divider output sits high in reset, so the edge detector starts high too.
    always_ff @(posedge CLK_IN or negedge n_RST) begin
        if (!n_RST) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            irq_q       <= 1'b0;
            ovr_q       <= 1'b0;
            tick_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tick_prev_q <= TICK_IN;
            if (LOAD) reload_q <= LOAD_VAL;
            if (expire) irq_q <= 1'b1;
            else if (IRQ_ACK) irq_q <= 1'b0;
            if (IRQ_ACK) ovr_q <= 1'b0;
            else if (expire && irq_q) ovr_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LOAD) count_d = LOAD_VAL;
                if (START && (eff_count != '0)) state_d = RUN;
            end
            RUN: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (LOAD) begin
                    count_d = LOAD_VAL;
                    if (LOAD_VAL == '0) state_d = IDLE;
                end else if (tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (count_q == WIDTH'(1)) begin
                        expire = 1'b1;
                        if (AUTO && (reload_q != '0)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign COUNT   = count_q;
    assign BUSY    = (state_q == RUN);
    assign IRQ     = irq_q;
    assign OVERRUN = ovr_q;

endmodule

// File: doc/tick_countdown_timer.md
TICK_COUNTDOWN_TIMER -- requirements
Module: tick_countdown_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, width of the count and load value.
REQ-002 SHALL have port: CLK_IN  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: n_RST  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: TICK_IN  input  1  divided-clock level from the divide-by-50 divider; synchronous to CLK_IN; low-to-high transition = one tick.
REQ-005 SHALL have port: LOAD  input  1  one-cycle strobe; capture LOAD_VAL.
REQ-006 SHALL have port: LOAD_VAL  input  WIDTH  count/reload value.
REQ-007 SHALL have port: START  input  1  one-cycle strobe; begin counting.
REQ-008 SHALL have port: STOP  input  1  one-cycle strobe; halt counting, hold COUNT.
REQ-009 SHALL have port: AUTO  input  1  level; 1 = reload and keep running on expiry.
REQ-010 SHALL have port: IRQ_ACK  input  1  one-cycle strobe; clear IRQ and OVERRUN.
REQ-011 SHALL have port: COUNT  output  WIDTH  current count, registered.
REQ-012 SHALL have port: BUSY  output  1  1 while in state RUN.
REQ-013 SHALL have port: IRQ  output  1  sticky expiry flag.
REQ-014 SHALL have port: OVERRUN  output  1  sticky; expiry occurred while IRQ already 1.

Function
REQ-015 SHALL register TICK_IN into TICK_PREV each cycle; tick event = TICK_IN & ~TICK_PREV; one event per low-to-high transition, regardless of how long TICK_IN stays high.
REQ-016 SHALL hold LOAD_VAL in an internal RELOAD register on every LOAD, in any state.
REQ-017 SHALL implement two states: IDLE (BUSY=0), RUN (BUSY=1).
REQ-018 IDLE: LOAD -> COUNT=LOAD_VAL next cycle; tick events ignored; STOP ignored.
REQ-019 IDLE: START with effective count nonzero -> RUN next cycle; effective count = LOAD_VAL if LOAD same cycle, else COUNT; START with effective count 0 -> ignored, stay IDLE.
REQ-020 RUN, per-cycle priority: STOP > LOAD > tick event; START ignored.
REQ-021 RUN + STOP -> IDLE, COUNT held (a LOAD in the same cycle still updates RELOAD only).
REQ-022 RUN + LOAD (no STOP) -> COUNT=LOAD_VAL, stay RUN, same-cycle tick dropped; LOAD_VAL=0 -> IDLE, no IRQ.
REQ-023 RUN + tick, COUNT>1 -> COUNT=COUNT-1.
REQ-024 RUN + tick, COUNT==1 -> expiry: IRQ=1 next cycle; AUTO=1 -> COUNT=RELOAD, stay RUN (RELOAD==0 -> COUNT=0, IDLE); AUTO=0 -> COUNT=0, IDLE.
REQ-025 COUNT SHALL never decrement below 0 nor wrap.
REQ-026 OVERRUN SHALL set on expiry when IRQ already 1.
REQ-027 IRQ_ACK SHALL clear IRQ and OVERRUN next cycle; expiry in the same cycle wins: IRQ stays 1, OVERRUN=0.
REQ-028 Latency: tick event in cycle N -> COUNT/IRQ/BUSY updated at edge ending cycle N (visible cycle N+1).

Reset
REQ-029 n_RST low SHALL immediately force: COUNT=0, RELOAD=0, state IDLE, BUSY=0, IRQ=0, OVERRUN=0, TICK_PREV=1.
REQ-030 TICK_PREV reset to 1 SHALL prevent a spurious tick from the divider's reset-high output on release.
REQ-031 Reset asserted mid-RUN SHALL abort counting; no IRQ on release.

Verification
REQ-032 Reset release, TICK_IN high for 25 cycles -> no tick event, COUNT=0, BUSY=0, IRQ=0.
REQ-033 LOAD 3 + START, TICK_IN driven by divide-by-50 divider (period 50) -> COUNT 3,2,1,0 on successive rising edges; IRQ=1 and BUSY=0 one cycle after third edge.
REQ-034 AUTO=1, LOAD 2, START -> IRQ after 2 ticks, COUNT=2, BUSY stays 1; no IRQ_ACK, 2 more ticks -> OVERRUN=1.
REQ-035 RUN with COUNT=5, STOP + LOAD 9 + tick same cycle -> IDLE, COUNT=5; next START -> COUNT=5.
REQ-036 IRQ=1 with expiry and IRQ_ACK same cycle -> IRQ=1, OVERRUN=0.
REQ-037 START with COUNT=0 -> BUSY stays 0; n_RST pulsed in RUN with COUNT=7 -> all outputs 0 immediately.
